// File: rtl/vco_adc_pkg.sv
// rtl/vco_adc_pkg.sv - ring-oscillator geometry and phase-code decode shared by the VCO ADC blocks
package vco_adc_pkg;

  localparam int NPHASE = 11;
  localparam int NPOS   = 2 * NPHASE;
  localparam int POS_W  = $clog2(NPOS);

  // Odd taps are inverted along the ring, so bit i carries i%2.
  localparam logic [NPHASE-1:0] PHASE_MASK = 11'b01010101010;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] pos;
  } pos_dec_t;

  // Thermometer fill (pos 0..NPHASE) or drain (pos NPHASE+1..2*NPHASE-1) of the ring.
  function automatic pos_dec_t decode_pos(input logic [NPHASE-1:0] sync);
    logic [NPHASE-1:0] q;
    logic [NPHASE-1:0] therm;
    pos_dec_t          r;
    q       = sync ^ PHASE_MASK;
    r.valid = 1'b0;
    r.pos   = '0;
    for (int k = 0; k <= NPHASE; k++) begin
      therm = NPHASE'((32'd1 << k) - 32'd1);
      if (q == therm) begin
        r.valid = 1'b1;
        r.pos   = POS_W'(k);
      end
      if ((k >= 1) && (k <= NPHASE - 1) && (q == ~therm)) begin
        r.valid = 1'b1;
        r.pos   = POS_W'(NPHASE + k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; DEPTH must be a power of two, at least 2
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vco_phase_counter.sv
// rtl/vco_phase_counter.sv - sync, decode and accumulate ring phase per decimation window into a sample FIFO
module vco_phase_counter
  import vco_adc_pkg::*;
#(
  parameter int DEC_W      = 16,
  parameter int OUT_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [NPHASE-1:0] phase_in,
  input  logic              enable_i,
  input  logic [DEC_W-1:0]  dec_ratio_i,
  output logic [OUT_W-1:0]  sample_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              overflow_o,
  output logic              code_err_o,
  input  logic              clear_flags_i
);

  logic [NPHASE-1:0] sync1_q, sync2_q;
  logic [POS_W-1:0]  pos_q, pos_prev_q;
  logic [1:0]        warm_q;
  logic              prime_q;
  logic [DEC_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              code_err_q, overflow_q;

  pos_dec_t          dec;
  logic              err_evt;
  logic [POS_W:0]    delta_w;
  logic [POS_W-1:0]  delta;
  logic [DEC_W-1:0]  ratio_m1, cur_cnt;
  logic [OUT_W:0]    sum_w;
  logic [OUT_W-1:0]  acc_sum;
  logic              push, drop;
  logic              fifo_full, fifo_empty;

  assign dec = decode_pos(sync2_q);

  // The sync chain holds reset zeros for two edges; those are not real ring codes.
  assign err_evt = !dec.valid && (warm_q == 2'd2);

  always_comb begin
    if (pos_q >= pos_prev_q) begin
      delta_w = {1'b0, pos_q} - {1'b0, pos_prev_q};
    end else begin
      delta_w = {1'b0, pos_q} + (POS_W+1)'(NPOS) - {1'b0, pos_prev_q};
    end
  end

  assign delta    = prime_q ? '0 : delta_w[POS_W-1:0];
  assign ratio_m1 = (dec_ratio_i == '0) ? '0 : dec_ratio_i - DEC_W'(1);
  assign cur_cnt  = prime_q ? ratio_m1 : cnt_q;

  assign sum_w   = {1'b0, acc_q} + (OUT_W+1)'(delta);
  assign acc_sum = sum_w[OUT_W] ? '1 : sum_w[OUT_W-1:0];

  assign push = enable_i && (cur_cnt == '0);
  assign drop = push && fifo_full && !(sample_ready_i && !fifo_empty);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (!enable_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cur_cnt == '0) begin
      acc_d = '0;
      cnt_d = ratio_m1;
    end else begin
      acc_d = acc_sum;
      cnt_d = cur_cnt - DEC_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      pos_q      <= '0;
      pos_prev_q <= '0;
      warm_q     <= '0;
      prime_q    <= 1'b1;
      cnt_q      <= '0;
      acc_q      <= '0;
      code_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= phase_in;
      sync2_q    <= sync1_q;
      if (dec.valid) begin
        pos_q <= dec.pos;
      end
      pos_prev_q <= pos_q;
      if (warm_q != 2'd2) begin
        warm_q <= warm_q + 2'd1;
      end
      prime_q    <= !enable_i;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      code_err_q <= err_evt || (code_err_q && !clear_flags_i);
      overflow_q <= drop || (overflow_q && !clear_flags_i);
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .push_i  (push),
    .data_i  (acc_sum),
    .pop_i   (sample_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (sample_o)
  );

  assign sample_valid_o = !fifo_empty;
  assign overflow_o     = overflow_q;
  assign code_err_o     = code_err_q;

endmodule
